bin2bcd_pair_seq: RTL and testbench

- Sequential binary-to-BCD converter that produces the three two-digit pairs feeding the LCD top level: TensBin1/OnesBin1, TensBin2/OnesBin2 and TensBin3/OnesBin3.
- Takes three unsigned binary values from the CPU datapath (e.g. PC, ALU result, register value).
- Converts them one after another with shift-add-3 (double dabble), one shift per clock.
- Publishes all six digits atomically so the LCD never shows a torn frame.

---
 rtl/bin2bcd_pair_seq.sv | 133 +++++++++++++
 tb/tb_bin2bcd_pair_seq.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_pair_seq.sv
// Sequential double-dabble converter: three binary values -> three BCD tens/ones pairs, committed atomically.
// Optional build macro BCD_SAT_EN: a channel >= 100 commits 9,9 instead of value mod 100.
module bin2bcd_pair_seq #(
  parameter int WIDTH = 8
) (
  input  logic             iCLK_50MHZ,
  input  logic             iRST_N,
  input  logic             iStart,
  input  logic [WIDTH-1:0] iVal1,
  input  logic [WIDTH-1:0] iVal2,
  input  logic [WIDTH-1:0] iVal3,
  output logic [3:0]       oTensBin1,
  output logic [3:0]       oOnesBin1,
  output logic [3:0]       oTensBin2,
  output logic [3:0]       oOnesBin2,
  output logic [3:0]       oTensBin3,
  output logic [3:0]       oOnesBin3,
  output logic [2:0]       oOvf,
  output logic             oBusy,
  output logic             oDone
);

  localparam int SR_W = WIDTH + 12;

  typedef enum logic [1:0] {IDLE, CONV, STORE, COMMIT} state_t;

  state_t            state_q, state_d;
  logic [1:0]        chan_q;
  logic [3:0]        bit_q;
  logic [SR_W-1:0]   sr_q;
  logic [WIDTH-1:0]  snap2_q, snap3_q;
  logic [WIDTH-1:0]  next_snap;
  logic [11:0]       shadow_q [3];

  // One double-dabble step: correct each BCD nibble above the binary field, then shift.
  function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] sr);
    logic [SR_W-1:0] t;
    t = sr;
    for (int d = 0; d < 3; d++) begin
      if (t[WIDTH+4*d +: 4] >= 4'd5) t[WIDTH+4*d +: 4] = t[WIDTH+4*d +: 4] + 4'd3;
    end
    return {t[SR_W-2:0], 1'b0};
  endfunction

  // Maps a {hundreds, tens, ones} shadow to the displayed {tens, ones} pair.
  function automatic logic [7:0] pair_out(input logic [11:0] bcd);
`ifdef BCD_SAT_EN
    return (bcd[11:8] != 4'd0) ? 8'h99 : bcd[7:0];
`else
    return bcd[7:0];
`endif
  endfunction

  always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
    if (!iRST_N) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // NOTE: give every always_comb output a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (iStart) state_d = CONV;
      CONV:   if (bit_q == 4'(WIDTH - 1)) state_d = STORE;
      STORE:  state_d = (chan_q == 2'd2) ? COMMIT : CONV;
      COMMIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    next_snap = snap2_q;
    if (chan_q == 2'd1) next_snap = snap3_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
    if (!iRST_N) begin
      chan_q    <= 2'd0;
      bit_q     <= 4'd0;
      sr_q      <= '0;
      snap2_q   <= '0;
      snap3_q   <= '0;
      // NOTE: the shadows are plain flops, not a RAM, so they take the async reset like the rest.
      for (int k = 0; k < 3; k++) shadow_q[k] <= 12'd0;
      oTensBin1 <= 4'd0;
      oOnesBin1 <= 4'd0;
      oTensBin2 <= 4'd0;
      oOnesBin2 <= 4'd0;
      oTensBin3 <= 4'd0;
      oOnesBin3 <= 4'd0;
      oOvf      <= 3'd0;
      oBusy     <= 1'b0;
      oDone     <= 1'b0;
    end else begin
      oDone <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (iStart) begin
            snap2_q <= iVal2;
            snap3_q <= iVal3;
            sr_q    <= {12'd0, iVal1};
            bit_q   <= 4'd0;
            chan_q  <= 2'd0;
            oBusy   <= 1'b1;
          end
        end
        CONV: begin
          sr_q  <= dabble_step(sr_q);
          bit_q <= bit_q + 4'd1;
        end
        STORE: begin
          shadow_q[chan_q] <= sr_q[SR_W-1:WIDTH];
          if (chan_q != 2'd2) begin
            chan_q <= chan_q + 2'd1;
            sr_q   <= {12'd0, next_snap};
            bit_q  <= 4'd0;
          end
        end
        COMMIT: begin
          {oTensBin1, oOnesBin1} <= pair_out(shadow_q[0]);
          {oTensBin2, oOnesBin2} <= pair_out(shadow_q[1]);
          {oTensBin3, oOnesBin3} <= pair_out(shadow_q[2]);
          oOvf  <= {shadow_q[2][11:8] != 4'd0, shadow_q[1][11:8] != 4'd0, shadow_q[0][11:8] != 4'd0};
          oDone <= 1'b1;
          oBusy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_pair_seq.sv
// Self-checking bench for bin2bcd_pair_seq: WIDTH=8 main instance plus WIDTH=4 and WIDTH=9 instances.
module tb_bin2bcd_pair_seq;

  logic       clk, rst_n;
  logic       start, start4, start9;
  logic [7:0] v1, v2, v3;
  logic [3:0] a1, a2, a3;
  logic [8:0] b1, b2, b3;
  logic [3:0] dig8 [6];
  logic [3:0] dig4 [6];
  logic [3:0] dig9 [6];
  logic [2:0] ovf8, ovf4, ovf9;
  logic       busy8, busy4, busy9, done8, done4, done9;

  int checks = 0;
  int errors = 0;

  bin2bcd_pair_seq #(.WIDTH(8)) dut (
    .iCLK_50MHZ(clk), .iRST_N(rst_n), .iStart(start),
    .iVal1(v1), .iVal2(v2), .iVal3(v3),
    .oTensBin1(dig8[0]), .oOnesBin1(dig8[1]), .oTensBin2(dig8[2]),
    .oOnesBin2(dig8[3]), .oTensBin3(dig8[4]), .oOnesBin3(dig8[5]),
    .oOvf(ovf8), .oBusy(busy8), .oDone(done8));

  bin2bcd_pair_seq #(.WIDTH(4)) dut4 (
    .iCLK_50MHZ(clk), .iRST_N(rst_n), .iStart(start4),
    .iVal1(a1), .iVal2(a2), .iVal3(a3),
    .oTensBin1(dig4[0]), .oOnesBin1(dig4[1]), .oTensBin2(dig4[2]),
    .oOnesBin2(dig4[3]), .oTensBin3(dig4[4]), .oOnesBin3(dig4[5]),
    .oOvf(ovf4), .oBusy(busy4), .oDone(done4));

  bin2bcd_pair_seq #(.WIDTH(9)) dut9 (
    .iCLK_50MHZ(clk), .iRST_N(rst_n), .iStart(start9),
    .iVal1(b1), .iVal2(b2), .iVal3(b3),
    .oTensBin1(dig9[0]), .oOnesBin1(dig9[1]), .oTensBin2(dig9[2]),
    .oOnesBin2(dig9[3]), .oTensBin3(dig9[4]), .oOnesBin3(dig9[5]),
    .oOvf(ovf9), .oBusy(busy9), .oDone(done9));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: displayed pair from plain decimal arithmetic.
  function automatic logic [7:0] exp_pair(input int v);
`ifdef BCD_SAT_EN
    if (v >= 100) return 8'h99;
`endif
    return {4'((v % 100) / 10), 4'(v % 10)};
  endfunction

  function automatic logic [23:0] exp_all(input int x, input int y, input int z);
    return {exp_pair(x), exp_pair(y), exp_pair(z)};
  endfunction

  function automatic logic [2:0] exp_ovf(input int x, input int y, input int z);
    return {z >= 100, y >= 100, x >= 100};
  endfunction

  function automatic logic [23:0] pack(input logic [3:0] d [6]);
    return {d[0], d[1], d[2], d[3], d[4], d[5]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses start on the WIDTH=8 instance and counts edges from the accepting edge to oDone.
  task automatic do_conv(input int x, input int y, input int z, output int n, output bit busy_ok);
    v1 = 8'(x); v2 = 8'(y); v3 = 8'(z);
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    busy_ok = (busy8 === 1'b1);
    while (n < 100) begin
      tick();
      n++;
      if (done8 === 1'b1) break;
      if (busy8 !== 1'b1) busy_ok = 1'b0;
    end
    if (busy8 !== 1'b0) busy_ok = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; start4 = 1'b0; start9 = 1'b0;
    v1 = '0; v2 = '0; v3 = '0; a1 = '0; a2 = '0; a3 = '0; b1 = '0; b2 = '0; b3 = '0;
    #12 rst_n = 1'b1;
    repeat (3) tick();
    checks++;
    if (pack(dig8) !== 24'h0 || ovf8 !== 3'b000 || busy8 !== 1'b0 || done8 !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: digits=%h ovf=%b busy=%b done=%b, want 000000/000/0/0",
               pack(dig8), ovf8, busy8, done8);
    end
  endtask

  task automatic test_conv(input string name, input int x, input int y, input int z);
    int n;
    bit busy_ok;
    do_conv(x, y, z, n, busy_ok);
    checks++;
    if (n != 28) begin
      errors++;
      $display("FAIL %s_latency: got %0d edges, want 28", name, n);
    end
    checks++;
    if (pack(dig8) !== exp_all(x, y, z) || ovf8 !== exp_ovf(x, y, z)) begin
      errors++;
      $display("FAIL %s_digits (%0d,%0d,%0d): got %h ovf=%b, want %h ovf=%b", name, x, y, z,
               pack(dig8), ovf8, exp_all(x, y, z), exp_ovf(x, y, z));
    end
    checks++;
    if (!busy_ok) begin
      errors++;
      $display("FAIL %s_busy: busy not high for exactly the conversion window", name);
    end
    tick();
    checks++;
    if (done8 !== 1'b0 || pack(dig8) !== exp_all(x, y, z)) begin
      errors++;
      $display("FAIL %s_hold: done=%b digits=%h, want done=0 digits=%h", name, done8,
               pack(dig8), exp_all(x, y, z));
    end
  endtask

  task automatic test_basic();
    test_conv("basic", 42, 7, 99);
  endtask

  task automatic test_overflow();
    test_conv("overflow", 100, 255, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      test_conv("random", int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 255)));
    end
  endtask

  task automatic test_back_to_back();
    int n, m;
    v1 = 8'd12; v2 = 8'd0; v3 = 8'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    repeat (4) begin tick(); n++; end
    v1 = 8'd34;
    start = 1'b1;
    tick(); n++;
    start = 1'b0;
    while (n < 100) begin
      tick(); n++;
      if (done8 === 1'b1) break;
      if (n == 26) start = 1'b1;
    end
    checks++;
    if (n != 28 || dig8[0] !== 4'd1 || dig8[1] !== 4'd2) begin
      errors++;
      $display("FAIL busy_ignore: done after %0d edges pair1=%0d,%0d, want 28 and 1,2",
               n, dig8[0], dig8[1]);
    end
    tick();
    start = 1'b0;
    m = 0;
    checks++;
    if (busy8 !== 1'b1 || done8 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b done=%b after oDone cycle, want 1/0", busy8, done8);
    end
    while (m < 100) begin
      tick(); m++;
      if (done8 === 1'b1) break;
    end
    checks++;
    if (m != 28 || dig8[0] !== 4'd3 || dig8[1] !== 4'd4) begin
      errors++;
      $display("FAIL b2b_commit: done after %0d edges pair1=%0d,%0d, want 28 and 3,4",
               m, dig8[0], dig8[1]);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int n;
    bit busy_ok;
    v1 = 8'd77; v2 = 8'd88; v3 = 8'd99;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (15) tick();
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (pack(dig8) !== 24'h0 || ovf8 !== 3'b000 || busy8 !== 1'b0 || done8 !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_async: digits=%h ovf=%b busy=%b done=%b, want all 0",
               pack(dig8), ovf8, busy8, done8);
    end
    #2 rst_n = 1'b1;
    repeat (20) begin
      tick();
      if (done8 !== 1'b0) break;
    end
    checks++;
    if (done8 !== 1'b0 || busy8 !== 1'b0 || pack(dig8) !== 24'h0) begin
      errors++;
      $display("FAIL reset_mid_discard: done=%b busy=%b digits=%h, want 0/0/000000",
               done8, busy8, pack(dig8));
    end
    do_conv(0, 0, 63, n, busy_ok);
    checks++;
    if (n != 28 || dig8[4] !== 4'd6 || dig8[5] !== 4'd3) begin
      errors++;
      $display("FAIL reset_mid_restart: %0d edges pair3=%0d,%0d, want 28 and 6,3",
               n, dig8[4], dig8[5]);
    end
    tick();
  endtask

  task automatic test_width();
    int n;
    a1 = 4'd15; a2 = 4'd15; a3 = 4'd15;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    n = 0;
    while (n < 100) begin
      tick(); n++;
      if (done4 === 1'b1) break;
    end
    checks++;
    if (n != 16 || pack(dig4) !== exp_all(15, 15, 15) || ovf4 !== 3'b000) begin
      errors++;
      $display("FAIL width4: %0d edges digits=%h ovf=%b, want 16 %h 000",
               n, pack(dig4), ovf4, exp_all(15, 15, 15));
    end
    b1 = 9'd511; b2 = 9'd100; b3 = 9'd99;
    start9 = 1'b1;
    tick();
    start9 = 1'b0;
    n = 0;
    while (n < 100) begin
      tick(); n++;
      if (done9 === 1'b1) break;
    end
    checks++;
    if (n != 31 || pack(dig9) !== exp_all(511, 100, 99) || ovf9 !== exp_ovf(511, 100, 99)) begin
      errors++;
      $display("FAIL width9: %0d edges digits=%h ovf=%b, want 31 %h %b",
               n, pack(dig9), ovf9, exp_all(511, 100, 99), exp_ovf(511, 100, 99));
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_width();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
